// File: rtl/maxpool_ctrl_pkg.sv
// Shared types and constants for the max-pooling sequencer and its position counter.
package maxpool_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int POOL_DEF = 2;
    localparam int WIN      = POOL_DEF * POOL_DEF;
    localparam int ELEM_W   = $clog2(WIN);

    function automatic int win_of(input int pool);
        return pool * pool;
    endfunction

endpackage

// File: rtl/maxpool_ctrl_if.sv
// Pixel-in / window-out stream bundle between the conv output and the pooled writeback.
// Handshake: a transfer happens in a cycle where valid && ready are both high; the
// valid side never drops valid or changes row/col before that transfer completes.
interface maxpool_ctrl_if #(parameter int CNT_W = 8);

    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_col;
    logic [CNT_W-1:0] out_row;

    modport master (
        input  in_valid, out_ready,
        output in_ready, out_valid, out_col, out_row
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, out_valid, out_col, out_row
    );

endinterface

// File: rtl/pool_pos_cnt.sv
// 2-D window position counter: column-fastest, wraps to (0,0) after the last window.
module pool_pos_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] dim_w,
    input  logic [W-1:0] dim_h,
    output logic [W-1:0] col,
    output logic [W-1:0] row,
    output logic         last
);

    logic col_end;

    assign col_end = (col == dim_w - W'(1));
    assign last    = col_end && (row == dim_h - W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (last) begin
                col <= '0;
                row <= '0;
            end else if (col_end) begin
                col <= '0;
                row <= row + W'(1);
            end else begin
                col <= col + W'(1);
            end
        end
    end

endmodule

// File: rtl/maxpool_ctrl.sv
// Max-pooling sequencer: drives the running-max register and comparator bypass,
// and presents one result per POOL*POOL-beat window with output backpressure.
module maxpool_ctrl
    import maxpool_ctrl_pkg::*;
#(
    parameter int POOL  = POOL_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             master_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_out_w,
    input  logic [CNT_W-1:0] cfg_out_h,
    maxpool_ctrl_if.master   bus,
    output logic             mr_ce,
    output logic             mr_rst_m,
    output logic             cmp_first,
    output logic             busy,
    output logic             done,
    output state_t           dbg_state
);

    localparam int WIN_P  = win_of(POOL);
    localparam int ELEM_P = $clog2(WIN_P);

    state_t            state, state_nxt;
    logic [ELEM_P-1:0] elem_cnt;
    logic [CNT_W-1:0]  cfg_w, cfg_h;
    logic              beat, pos_clr, pos_adv, pos_last;
    logic              in_ready, out_valid;

    pool_pos_cnt #(.W(CNT_W)) u_pos (
        .clk   (clk),
        .rst   (master_rst),
        .clr   (pos_clr),
        .adv   (pos_adv),
        .dim_w (cfg_w),
        .dim_h (cfg_h),
        .col   (bus.out_col),
        .row   (bus.out_row),
        .last  (pos_last)
    );

    always_ff @(posedge clk) begin
        if (master_rst) begin
            state    <= IDLE;
            elem_cnt <= '0;
            cfg_w    <= '0;
            cfg_h    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                cfg_w <= cfg_out_w;
                cfg_h <= cfg_out_h;
            end
            if (beat) begin
                elem_cnt <= (elem_cnt == ELEM_P'(WIN_P - 1)) ? '0 : elem_cnt + ELEM_P'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        beat      = 1'b0;
        mr_ce     = 1'b0;
        mr_rst_m  = 1'b0;
        cmp_first = 1'b0;
        pos_clr   = 1'b0;
        pos_adv   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    pos_clr = 1'b1;
                    if (cfg_out_w == '0 || cfg_out_h == '0) begin
                        state_nxt = FIN;
                    end else begin
                        // Clear the max register once so the pass starts from a known value.
                        state_nxt = RUN;
                        mr_ce     = 1'b1;
                        mr_rst_m  = 1'b1;
                    end
                end
            end
            RUN: begin
                in_ready  = 1'b1;
                beat      = bus.in_valid;
                mr_ce     = beat;
                cmp_first = beat && (elem_cnt == '0);
                if (beat && elem_cnt == ELEM_P'(WIN_P - 1)) state_nxt = HOLD;
            end
            HOLD: begin
                // Register holds the finished maximum; no input beat shares this cycle.
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    pos_adv   = 1'b1;
                    state_nxt = pos_last ? FIN : RUN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy          = (state == RUN) || (state == HOLD);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign dbg_state     = state;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Self-checking bench for maxpool_ctrl: directed scenarios plus randomized passes
// checked against a window-level protocol model.
module tb_maxpool_ctrl;
    import maxpool_ctrl_pkg::*;

    localparam int CNT_W = 8;
    localparam int W_WIN = POOL_DEF * POOL_DEF;

    logic             clk = 1'b0;
    logic             master_rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfg_out_w = '0;
    logic [CNT_W-1:0] cfg_out_h = '0;
    logic             mr_ce, mr_rst_m, cmp_first, busy, done;
    state_t           dbg_state;

    maxpool_ctrl_if #(.CNT_W(CNT_W)) bus ();

    maxpool_ctrl #(.POOL(POOL_DEF), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .master_rst(master_rst),
        .start     (start),
        .cfg_out_w (cfg_out_w),
        .cfg_out_h (cfg_out_h),
        .bus       (bus.master),
        .mr_ce     (mr_ce),
        .mr_rst_m  (mr_rst_m),
        .cmp_first (cmp_first),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*CNT_W-1:0] exp_q[$];
    int ov_q[$];
    int first_q[$];
    int beat_q[$];
    int done_cyc;

    function automatic logic [6:0] obs_vec();
        return {bus.in_ready, bus.out_valid, mr_ce, mr_rst_m, cmp_first, busy, done};
    endfunction

    // vmode: 0 always valid, 1 alternating 1010, 2 random
    // rmode: 0 always ready, 1 low for 5 cycles of each hold, 2 random
    task automatic run_pass(input int w, input int h, input int vmode, input int rmode,
                            input bit noise);
        logic [6:0] obs, exp;
        int  cyc = 0;
        int  beats = 0;
        int  hold_len = 0;
        bit  hold = 0;
        bit  fin;
        bit  seen_done = 0;
        bit  nz;
        exp_q.delete(); ov_q.delete(); first_q.delete(); beat_q.delete();
        done_cyc = -1;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                exp_q.push_back({CNT_W'(r), CNT_W'(c)});
        nz = (w != 0) && (h != 0);

        @(posedge clk); #1;
        start = 1'b1; cfg_out_w = CNT_W'(w); cfg_out_h = CNT_W'(h);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        exp = {2'b00, nz, nz, 3'b000};
        obs = obs_vec();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL start_cycle w=%0d h=%0d got=%b want=%b", w, h, obs, exp);
        end
        fin = !nz;

        for (int i = 0; i < 1000 && !seen_done; i++) begin
            @(posedge clk); #1;
            cyc++;
            start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (noise) begin
                cfg_out_w = CNT_W'($urandom_range(0, 5));
                cfg_out_h = CNT_W'($urandom_range(0, 5));
                if (fin) start = 1'b1;
            end
            case (vmode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = cyc[0];
                default: bus.in_valid = 1'($urandom_range(0, 1));
            endcase
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = hold && (hold_len >= 5);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            obs = obs_vec();
            if (obs[6] && obs[4]) beat_q.push_back(cyc);
            if (obs[2]) first_q.push_back(cyc);
            if (obs[5]) ov_q.push_back(cyc);
            if (obs[0]) done_cyc = cyc;

            if (fin)       exp = 7'b0000001;
            else if (hold) exp = 7'b0100010;
            else           exp = {1'b1, 1'b0, bus.in_valid, 1'b0,
                                  bus.in_valid && (beats == 0), 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL pass_cycle w=%0d h=%0d cyc=%0d got=%b want=%b", w, h, cyc, obs, exp);
            end
            if (hold) begin
                n_checks++;
                if ({bus.out_row, bus.out_col} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL window_pos cyc=%0d got=(%0d,%0d) want=(%0d,%0d)", cyc,
                             bus.out_row, bus.out_col, exp_q[0][2*CNT_W-1:CNT_W],
                             exp_q[0][CNT_W-1:0]);
                end
            end

            if (fin) begin
                seen_done = 1'b1;
            end else if (hold) begin
                hold_len++;
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    hold = 1'b0;
                    hold_len = 0;
                    if (exp_q.size() == 0) fin = 1'b1;
                end
            end else if (bus.in_valid) begin
                beats++;
                if (beats == W_WIN) begin
                    beats = 0;
                    hold = 1'b1;
                end
            end
        end

        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL pass_timeout w=%0d h=%0d got=no_done want=done", w, h);
        end else begin
            // Cycle after done: back in IDLE, the start seen during done was dropped.
            @(posedge clk); #1;
            start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
            @(negedge clk);
            obs = obs_vec();
            n_checks++;
            if (obs !== 7'b0) begin
                n_fail++;
                $display("FAIL post_done_idle got=%b want=%b", obs, 7'b0);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        logic [6+2*CNT_W:0] v;
        v = {obs_vec(), bus.out_row, bus.out_col};
        n_checks++;
        if (v !== '0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL %s got=%h state=%0d want=0 state=0", name, v, dbg_state);
        end
    endtask

    task automatic test_reset;
        master_rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 master_rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");
    endtask

    task automatic test_basic;
        int exp_beats[8] = '{1, 2, 3, 4, 6, 7, 8, 9};
        run_pass(2, 1, 0, 0, 1'b0);
        n_checks++;
        if (beat_q.size() != 8) begin
            n_fail++;
            $display("FAIL basic_beat_count got=%0d want=8", beat_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (beat_q[k] != exp_beats[k]) begin
                    n_fail++;
                    $display("FAIL basic_beat_cycle idx=%0d got=%0d want=%0d", k, beat_q[k], exp_beats[k]);
                end
            end
        end
        n_checks++;
        if (first_q.size() != 2 || first_q[0] != 1 || first_q[1] != 6) begin
            n_fail++;
            $display("FAIL basic_cmp_first got=%p want=1,6", first_q);
        end
        n_checks++;
        if (ov_q.size() != 2 || ov_q[0] != 5 || ov_q[1] != 10) begin
            n_fail++;
            $display("FAIL basic_out_valid got=%p want=5,10", ov_q);
        end
        n_checks++;
        if (done_cyc != 11) begin
            n_fail++;
            $display("FAIL basic_done_cycle got=%0d want=11", done_cyc);
        end
    endtask

    task automatic test_backpressure;
        run_pass(2, 2, 0, 1, 1'b0);
        n_checks++;
        if (ov_q.size() != 4 * 6) begin
            n_fail++;
            $display("FAIL bp_out_valid_cycles got=%0d want=24", ov_q.size());
        end
    endtask

    task automatic test_bubbles;
        run_pass(1, 2, 1, 0, 1'b0);
        run_pass(2, 1, 1, 2, 1'b0);
    endtask

    task automatic test_zero_cfg;
        run_pass(0, 3, 0, 0, 1'b0);
        n_checks++;
        if (done_cyc != 1 || ov_q.size() != 0 || beat_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_w done=%0d ov=%0d beats=%0d want 1,0,0", done_cyc, ov_q.size(), beat_q.size());
        end
        run_pass(2, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_pass;
        @(posedge clk); #1;
        start = 1'b1; cfg_out_w = 8'd2; cfg_out_h = 8'd2;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        master_rst = 1'b1; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        master_rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_mid_pass");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_done k=%0d got done=%b busy=%b want 0,0", k, done, busy);
            end
        end
        run_pass(2, 2, 2, 2, 1'b0);
    endtask

    task automatic test_row_wrap;
        run_pass(3, 2, 0, 0, 1'b1);
        run_pass(3, 2, 2, 2, 1'b1);
    endtask

    task automatic test_random;
        for (int k = 0; k < 6; k++)
            run_pass($urandom_range(1, 4), $urandom_range(1, 4), 2, 2, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_bubbles();
        test_zero_cfg();
        test_reset_mid_pass();
        test_row_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
